// File: rtl/cart_mem_pkg.sv
// Shared types and constants for the cartridge memory responder.
// Channel ids, FSM encoding and iNES header field positions.
package cart_mem_pkg;

    typedef enum logic [1:0] {
        CH_PRG    = 2'd0,
        CH_CROM   = 2'd1,
        CH_CHRRAM = 2'd2
    } ch_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int          EXT_AW_DEF      = 23;
    localparam logic [22:0] CHRRAM_BASE_DEF = 23'h7FE000;

    localparam int HDR_PRG_LSB = 32;
    localparam int HDR_CHR_LSB = 40;
    localparam int HDR_FLD_W   = 8;
    // PRG size is counted in 16 KiB units, so CHR ROM starts at size << 14.
    localparam int PRG_BANK_SH = 14;

    function automatic ch_e rr_next(input ch_e c);
        unique case (c)
            CH_PRG:    return CH_CROM;
            CH_CROM:   return CH_CHRRAM;
            CH_CHRRAM: return CH_PRG;
        endcase
    endfunction

endpackage

// File: rtl/cart_rr_arb3.sv
// Three-way round-robin arbiter, purely combinational.
// Search begins at the channel after last_i and wraps.
module cart_rr_arb3
    import cart_mem_pkg::*;
(
    input  logic [2:0] pend_i,
    input  ch_e        last_i,
    output ch_e        gnt_o,
    output logic       vld_o
);

    ch_e c1;
    ch_e c2;
    ch_e c3;

    assign c1 = rr_next(last_i);
    assign c2 = rr_next(c1);
    assign c3 = rr_next(c2);

    always_comb begin
        gnt_o = c1;
        vld_o = 1'b1;
        if (pend_i[c1]) begin
            gnt_o = c1;
        end else if (pend_i[c2]) begin
            gnt_o = c2;
        end else if (pend_i[c3]) begin
            gnt_o = c3;
        end else begin
            vld_o = 1'b0;
        end
    end

endmodule

// File: rtl/cart_mem.sv
// Cartridge memory responder: arbitrates PRG ROM, CHR ROM and CHR RAM
// channels onto one byte-wide external port, one transaction at a time.
module cart_mem
    import cart_mem_pkg::*;
#(
    parameter int               EXT_AW      = EXT_AW_DEF,
    parameter logic [EXT_AW-1:0] CHRRAM_BASE = EXT_AW'(CHRRAM_BASE_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [127:0]      header,
    input  logic [20:0]       promaddr,
    input  logic              promreq,
    output logic              promack,
    output logic [7:0]        promdata,
    input  logic [20:0]       cromaddr,
    input  logic              cromreq,
    output logic              cromack,
    output logic [7:0]        cromdata,
    input  logic [12:0]       chrramaddr,
    input  logic [7:0]        chrramwdata,
    input  logic              chrramwr,
    input  logic              chrramreq,
    output logic              chrramack,
    output logic [7:0]        chrramrdata,
    output logic [EXT_AW-1:0] extaddr,
    output logic [7:0]        extwdata,
    output logic              extwr,
    output logic              extreq,
    input  logic              extack,
    input  logic [7:0]        extrdata
);

    state_e            state_q, state_d;
    ch_e               grant_q, grant_d;
    ch_e               last_q, last_d;
    logic [2:0]        armed_q, armed_d;
    logic [2:0]        ack_q, ack_d;
    logic [EXT_AW-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              req_q, req_d;
    logic [7:0]        prd_q, prd_d;
    logic [7:0]        crd_q, crd_d;
    logic [7:0]        rrd_q, rrd_d;

    logic [2:0]        reqs;
    logic [2:0]        pend;
    ch_e               arb_gnt;
    logic              arb_vld;
    logic [EXT_AW-1:0] prg_addr;
    logic [EXT_AW-1:0] crom_addr;
    logic [EXT_AW-1:0] ram_addr;
    logic              unused_hdr;

    assign reqs = {chrramreq, cromreq, promreq};
    assign pend = reqs & armed_q;

    assign prg_addr  = EXT_AW'(promaddr);
    assign crom_addr = EXT_AW'({header[HDR_PRG_LSB +: HDR_FLD_W],
                                {PRG_BANK_SH{1'b0}}})
                     + EXT_AW'(cromaddr);
    assign ram_addr  = CHRRAM_BASE + EXT_AW'(chrramaddr);

    assign unused_hdr = ^{header[127:HDR_PRG_LSB+HDR_FLD_W],
                          header[HDR_PRG_LSB-1:0]};

    cart_rr_arb3 u_arb (
        .pend_i (pend),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .vld_o  (arb_vld)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        req_d   = req_q;
        prd_d   = prd_q;
        crd_d   = crd_q;
        rrd_d   = rrd_q;
        ack_d   = 3'b000;
        // A low req re-arms its channel; an ack below disarms it.
        armed_d = armed_q | ~reqs;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_d = arb_gnt;
                    last_d  = arb_gnt;
                    req_d   = 1'b1;
                    state_d = ST_BUSY;
                    unique case (arb_gnt)
                        CH_PRG: begin
                            addr_d  = prg_addr;
                            wr_d    = 1'b0;
                            wdata_d = 8'h00;
                        end
                        CH_CROM: begin
                            addr_d  = crom_addr;
                            wr_d    = 1'b0;
                            wdata_d = 8'h00;
                        end
                        CH_CHRRAM: begin
                            addr_d  = ram_addr;
                            wr_d    = chrramwr;
                            wdata_d = chrramwdata;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                if (extack) begin
                    req_d            = 1'b0;
                    state_d          = ST_IDLE;
                    armed_d[grant_q] = 1'b0;
                    ack_d[grant_q]   = 1'b1;
                    if (!wr_q) begin
                        unique case (grant_q)
                            CH_PRG:    prd_d = extrdata;
                            CH_CROM:   crd_d = extrdata;
                            CH_CHRRAM: rrd_d = extrdata;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= CH_PRG;
            last_q  <= CH_CHRRAM;
            armed_q <= 3'b111;
            ack_q   <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            wr_q    <= 1'b0;
            req_q   <= 1'b0;
            prd_q   <= 8'h00;
            crd_q   <= 8'h00;
            rrd_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            armed_q <= armed_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            req_q   <= req_d;
            prd_q   <= prd_d;
            crd_q   <= crd_d;
            rrd_q   <= rrd_d;
        end
    end

    assign promack     = ack_q[CH_PRG];
    assign cromack     = ack_q[CH_CROM];
    assign chrramack   = ack_q[CH_CHRRAM];
    assign promdata    = prd_q;
    assign cromdata    = crd_q;
    assign chrramrdata = rrd_q;
    assign extaddr     = addr_q;
    assign extwdata    = wdata_q;
    assign extwr       = wr_q;
    assign extreq      = req_q;

endmodule

// File: tb/tb_cart_mem.sv
// Self-checking bench for cart_mem: directed cases plus a randomized
// run against a transaction-level model with a byte memory.
module tb_cart_mem;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] header;
    logic [20:0]  promaddr;
    logic         promreq;
    logic         promack;
    logic [7:0]   promdata;
    logic [20:0]  cromaddr;
    logic         cromreq;
    logic         cromack;
    logic [7:0]   cromdata;
    logic [12:0]  chrramaddr;
    logic [7:0]   chrramwdata;
    logic         chrramwr;
    logic         chrramreq;
    logic         chrramack;
    logic [7:0]   chrramrdata;
    logic [22:0]  extaddr;
    logic [7:0]   extwdata;
    logic         extwr;
    logic         extreq;
    logic         extack;
    logic [7:0]   extrdata;

    always #5 clk = ~clk;

    cart_mem dut (
        .clk         (clk),
        .reset       (reset),
        .header      (header),
        .promaddr    (promaddr),
        .promreq     (promreq),
        .promack     (promack),
        .promdata    (promdata),
        .cromaddr    (cromaddr),
        .cromreq     (cromreq),
        .cromack     (cromack),
        .cromdata    (cromdata),
        .chrramaddr  (chrramaddr),
        .chrramwdata (chrramwdata),
        .chrramwr    (chrramwr),
        .chrramreq   (chrramreq),
        .chrramack   (chrramack),
        .chrramrdata (chrramrdata),
        .extaddr     (extaddr),
        .extwdata    (extwdata),
        .extwr       (extwr),
        .extreq      (extreq),
        .extack      (extack),
        .extrdata    (extrdata)
    );

    logic [2:0] acks;
    assign acks = {chrramack, cromack, promack};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects a transaction already on the external port; completes it.
    task automatic do_txn(input string tag, input int ch,
                          input logic [22:0] a, input logic wr,
                          input logic [7:0] wd, input logic [7:0] rd);
        logic [2:0] ev;
        ev = 3'b001 << ch;
        chk({tag, ".extreq"}, 32'(extreq), 32'd1);
        chk({tag, ".addr"}, 32'(extaddr), 32'(a));
        chk({tag, ".wr"}, 32'(extwr), 32'(wr));
        if (wr) chk({tag, ".wdata"}, 32'(extwdata), 32'(wd));
        extack   = 1'b1;
        extrdata = rd;
        tick();
        extack   = 1'b0;
        extrdata = 8'h00;
        chk({tag, ".ack"}, 32'(acks), 32'(ev));
        chk({tag, ".reqlo"}, 32'(extreq), 32'd0);
    endtask

    logic [7:0] mem [logic [22:0]];

    function automatic logic [7:0] memrd(input logic [22:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]};
    endfunction

    // Random-phase model state
    bit         rq[3];
    bit         served[3];
    int         hold[3];
    logic [20:0] pa, ca;
    logic [12:0] ra;
    logic        rwr;
    logic [7:0]  rwd;
    bit         busy;
    int         dly;
    int         cur;
    int         last;
    int         exp_ack;
    logic [22:0] cur_addr;
    logic        cur_wr;
    logic [7:0]  cur_wd;
    bit [2:0]    prev_out;
    logic [7:0]  prev_prg;
    logic [7:0]  mdata[3];

    initial begin
        int cnt;
        int c;
        int j;
        logic [31:0] ea;
        logic [2:0]  ev;

        reset       = 1'b1;
        header      = '0;
        header[39:32] = 8'd2;
        header[47:40] = 8'd1;
        promaddr    = '0;
        promreq     = 1'b0;
        cromaddr    = '0;
        cromreq     = 1'b0;
        chrramaddr  = '0;
        chrramwdata = '0;
        chrramwr    = 1'b0;
        chrramreq   = 1'b0;
        extack      = 1'b0;
        extrdata    = '0;
        tick();
        tick();
        chk("rst.acks", 32'(acks), 32'd0);
        chk("rst.extreq", 32'(extreq), 32'd0);
        chk("rst.extwr", 32'(extwr), 32'd0);
        chk("rst.extaddr", 32'(extaddr), 32'd0);
        chk("rst.extwdata", 32'(extwdata), 32'd0);
        chk("rst.data", {8'h0, promdata, cromdata, chrramrdata}, 32'd0);
        reset = 1'b0;
        tick();

        promaddr = 21'h01234;
        promreq  = 1'b1;
        tick();
        do_txn("prg", 0, 23'h001234, 1'b0, 8'h00, 8'hA5);
        chk("prg.data", 32'(promdata), 32'hA5);
        promreq = 1'b0;
        tick();
        chk("prg.pulse", 32'(acks), 32'd0);

        cromaddr = 21'h00010;
        cromreq  = 1'b1;
        tick();
        do_txn("crom", 1, 23'h008010, 1'b0, 8'h00, 8'h3C);
        chk("crom.data", 32'(cromdata), 32'h3C);
        cromreq = 1'b0;
        tick();
        chk("crom.pulse", 32'(acks), 32'd0);

        chrramaddr  = 13'h1FFF;
        chrramwr    = 1'b1;
        chrramwdata = 8'h5A;
        chrramreq   = 1'b1;
        tick();
        do_txn("ramwr", 2, 23'h7FFFFF, 1'b1, 8'h5A, 8'hEE);
        chk("ramwr.rdata", 32'(chrramrdata), 32'd0);
        chrramreq = 1'b0;
        chrramwr  = 1'b0;
        tick();

        // Header change while busy must not move the latched address.
        header[39:32] = 8'hFF;
        cromaddr = 21'h1FFFFF;
        cromreq  = 1'b1;
        tick();
        header[39:32] = 8'h01;
        tick();
        chk("hdrchg.addr", 32'(extaddr), 32'h5FBFFF);
        do_txn("hdrchg", 1, 23'h5FBFFF, 1'b0, 8'h00, 8'h81);
        cromreq = 1'b0;
        header[39:32] = 8'd2;
        tick();

        reset = 1'b1;
        tick();
        reset      = 1'b0;
        promaddr   = 21'h00100;
        cromaddr   = 21'h00020;
        chrramaddr = 13'h0004;
        promreq    = 1'b1;
        cromreq    = 1'b1;
        chrramreq  = 1'b1;
        tick();
        do_txn("rr0", 0, 23'h000100, 1'b0, 8'h00, 8'h11);
        promreq = 1'b0;
        tick();
        promreq = 1'b1;
        do_txn("rr1", 1, 23'h008020, 1'b0, 8'h00, 8'h22);
        cromreq = 1'b0;
        tick();
        do_txn("rr2", 2, 23'h7FE004, 1'b0, 8'h00, 8'h33);
        chrramreq = 1'b0;
        tick();
        do_txn("rr3", 0, 23'h000100, 1'b0, 8'h00, 8'h44);
        chk("rr.data", {8'h0, promdata, cromdata, chrramrdata}, 32'h442233);

        cnt = 0;
        repeat (10) begin
            tick();
            if (extreq || acks != 3'b000) cnt++;
        end
        chk("hold.once", 32'(cnt), 32'd0);
        promreq = 1'b0;
        tick();
        promreq = 1'b1;
        tick();
        do_txn("rearm", 0, 23'h000100, 1'b0, 8'h00, 8'h55);
        chk("rearm.data", 32'(promdata), 32'h55);
        promreq = 1'b0;
        tick();

        promreq = 1'b1;
        tick();
        chk("rstmid.busy", 32'(extreq), 32'd1);
        reset   = 1'b1;
        promreq = 1'b0;
        tick();
        reset = 1'b0;
        chk("rstmid.extreq", 32'(extreq), 32'd0);
        chk("rstmid.acks", 32'(acks), 32'd0);
        extack   = 1'b1;
        extrdata = 8'hFF;
        tick();
        extack = 1'b0;
        chk("idleack.acks", 32'(acks), 32'd0);
        tick();
        chk("idleack.acks2", 32'(acks), 32'd0);
        chk("idleack.data", 32'(promdata), 32'd0);

        promreq = 1'b1;
        tick();
        extack   = 1'b1;
        extrdata = 8'h77;
        reset    = 1'b1;
        promreq  = 1'b0;
        tick();
        extack = 1'b0;
        reset  = 1'b0;
        chk("rstack.acks", 32'(acks), 32'd0);
        chk("rstack.extreq", 32'(extreq), 32'd0);
        tick();
        chk("rstack.acks2", 32'(acks), 32'd0);
        chk("rstack.data", 32'(promdata), 32'd0);

        promaddr = 21'h1FFFFF;
        promreq  = 1'b1;
        tick();
        do_txn("after", 0, 23'h1FFFFF, 1'b0, 8'h00, 8'h9C);
        chk("after.data", 32'(promdata), 32'h9C);
        promreq = 1'b0;
        tick();

        // Randomized phase from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rq[i] = 0;
            served[i] = 0;
            hold[i] = 0;
            mdata[i] = 8'h00;
        end
        pa = '0; ca = '0; ra = '0; rwr = 1'b0; rwd = '0;
        busy = 0; dly = 0; cur = 0; last = 2; exp_ack = -1;
        cur_addr = '0; cur_wr = 1'b0; cur_wd = '0;
        prev_out = 3'b000;
        prev_prg = header[39:32];

        repeat (4000) begin
            tick();
            ev = (exp_ack >= 0) ? (3'b001 << exp_ack) : 3'b000;
            chk("rnd.ack", 32'(acks), 32'(ev));
            if (exp_ack >= 0) begin
                served[exp_ack] = 1;
                chk("rnd.reqlo", 32'(extreq), 32'd0);
            end
            exp_ack = -1;
            chk("rnd.data", {8'h0, promdata, cromdata, chrramrdata},
                {8'h0, mdata[0], mdata[1], mdata[2]});

            if (busy) begin
                chk("rnd.hold", {7'h0, extreq, extwr, extaddr},
                    {7'h0, 1'b1, cur_wr, cur_addr});
            end else if (extreq) begin
                c = -1;
                for (int k = 1; k <= 3; k++) begin
                    j = (last + k) % 3;
                    if (c < 0 && prev_out[j]) c = j;
                end
                chk("rnd.spurious", 32'(c >= 0), 32'd1);
                if (c >= 0) begin
                    case (c)
                        0: ea = {11'h0, pa};
                        1: ea = ({24'h0, prev_prg} << 14) + {11'h0, ca};
                        default: ea = 32'h7FE000 + {19'h0, ra};
                    endcase
                    cur_addr = ea[22:0];
                    cur_wr   = (c == 2) ? rwr : 1'b0;
                    cur_wd   = rwd;
                    chk("rnd.addr", 32'(extaddr), 32'(cur_addr));
                    chk("rnd.wr", 32'(extwr), 32'(cur_wr));
                    if (cur_wr) chk("rnd.wdata", 32'(extwdata), 32'(cur_wd));
                    busy = 1;
                    cur  = c;
                    last = c;
                    dly  = int'($urandom % 4);
                end
            end

            extack = 1'b0;
            if (busy) begin
                if (dly == 0) begin
                    extack = 1'b1;
                    if (cur_wr) begin
                        mem[cur_addr] = cur_wd;
                        extrdata = 8'($urandom);
                    end else begin
                        extrdata = memrd(cur_addr);
                        mdata[cur] = extrdata;
                    end
                    exp_ack = cur;
                    busy = 0;
                end else begin
                    dly--;
                end
            end else if ($urandom % 16 == 0) begin
                extack   = 1'b1;
                extrdata = 8'($urandom);
            end

            if ($urandom % 8 == 0) header[39:32] = 8'($urandom);

            for (int i = 0; i < 3; i++) begin
                if (rq[i]) begin
                    if (served[i]) begin
                        if (hold[i] == 0) begin
                            rq[i] = 0;
                            served[i] = 0;
                        end else begin
                            hold[i]--;
                        end
                    end
                end else if ($urandom % 3 == 0) begin
                    rq[i] = 1;
                    hold[i] = int'($urandom % 4);
                    case (i)
                        0: pa = 21'($urandom);
                        1: ca = 21'($urandom);
                        default: begin
                            ra  = 13'($urandom);
                            rwr = 1'($urandom);
                            rwd = 8'($urandom);
                        end
                    endcase
                end
            end
            promreq     = rq[0];
            cromreq     = rq[1];
            chrramreq   = rq[2];
            promaddr    = pa;
            cromaddr    = ca;
            chrramaddr  = ra;
            chrramwr    = rwr;
            chrramwdata = rwd;
            for (int i = 0; i < 3; i++) prev_out[i] = rq[i] && !served[i];
            prev_prg = header[39:32];
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cart_mem.md
Name: cart_mem

Overview:
- Memory-side responder for the mapper's three cartridge memory channels: PRG ROM, CHR ROM and CHR RAM.
- Serves each mapper request/ack channel by arbitrating onto one external byte-wide memory port (SDRAM/BRAM controller).
- Translates channel-local addresses into the external cartridge image layout derived from the iNES header.
- Sits between the mapper and the external memory controller; a single outstanding external transaction at any time.

Parameters:
- EXT_AW, 23, external byte address width (8 MiB image space).
- CHRRAM_BASE, 23'h7FE000, external base address of the 8 KiB CHR RAM region.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- header  in  128  iNES header; [39:32] PRG size in 16 KiB units, [47:40] CHR size in 8 KiB units
- promaddr  in  21  PRG ROM byte address
- promreq  in  1  PRG read request, level
- promack  out  1  one-cycle ack; promdata valid in the same cycle
- promdata  out  8  PRG read data
- cromaddr  in  21  CHR ROM byte address
- cromreq  in  1  CHR ROM read request, level
- cromack  out  1  one-cycle ack
- cromdata  out  8  CHR ROM read data
- chrramaddr  in  13  CHR RAM byte address
- chrramwdata  in  8  CHR RAM write data
- chrramwr  in  1  1 = write, 0 = read; qualified by chrramreq
- chrramreq  in  1  CHR RAM request, level
- chrramack  out  1  one-cycle ack
- chrramrdata  out  8  CHR RAM read data
- extaddr  out  EXT_AW  external byte address
- extwdata  out  8  external write data
- extwr  out  1  external write strobe qualifier
- extreq  out  1  external request, held until extack
- extack  in  1  one-cycle external completion pulse
- extrdata  in  8  external read data, valid with extack

Behaviour:
- Reset values:
  - All ack outputs 0; extreq 0, extwr 0, extaddr 0, extwdata 0.
  - promdata, cromdata and chrramrdata are 0.
  - FSM in IDLE, round-robin pointer = CHRRAM, all channels armed.
- Arming:
  - Each channel has an armed flag; it clears when that channel is acked.
  - It re-sets on any cycle its req is sampled low.
  - A channel is pending when req=1 and armed=1. A req held high past its ack never causes a second transaction.
- Arbitration:
  - Round-robin in the order PRG -> CROM -> CHRRAM.
  - The search starts at the channel after the last-granted one; PRG wins first out of reset.
- FSM states: IDLE, BUSY.
  - IDLE: if any channel is pending, latch the grant, extaddr, extwr and extwdata, set extreq=1, and go to BUSY.
  - BUSY: hold extreq and all latched fields stable; on extack, deassert extreq, capture extrdata into the granted channel's rdata register (reads only), and go to IDLE.
- Channel ack: pulse for exactly 1 cycle, in the cycle after extack. The rdata register holds its value until the next read on that channel.
- Latency:
  - req rising in cycle N with the FSM idle -> extreq high in N+1.
  - extack in cycle M -> ack in M+1.
  - The next grant can be sampled in M+1, so extreq can be high again in M+2.
- Address map (unsigned, zero-extended to EXT_AW, overflow truncates):
  - PRG: extaddr = promaddr.
  - CROM: extaddr = {header[39:32], 14'b0} + cromaddr.
  - CHRRAM: extaddr = CHRRAM_BASE + chrramaddr.
- Write rules:
  - PRG and CROM are read-only; extwr = 0.
  - CHRRAM uses extwr = chrramwr. A write ack carries no data and leaves chrramrdata unchanged.
- Header changes mid-transaction do not affect the latched extaddr.
- extack while in IDLE is ignored: no ack and no data capture.
- Reset mid-operation:
  - extreq = 0 and the FSM goes to IDLE on the next cycle; no channel ack is issued.
  - The external controller tolerates request withdrawal; its late extack falls under the IDLE rule.
- If reset coincides with extack, reset wins: no ack and no capture.

Decomposition:
- Shared package: channel id constants (CH_PRG=0, CH_CROM=1, CH_CHRRAM=2), FSM state encoding, CHRRAM_BASE default, header field bit positions.
- One natural sub-module: cart_rr_arb3, a 3-way round-robin arbiter. Inputs: pending[2:0], last-grant pointer. Output: grant id plus a valid bit, purely combinational.

Test Plan:
- header[39:32]=2, header[47:40]=1; promreq with promaddr=21'h01234 -> extaddr=23'h001234, extwr=0; extack with extrdata=8'hA5 -> promack pulse next cycle, promdata=8'hA5.
- Same header; cromreq with cromaddr=21'h00010 -> extaddr=23'h008010; extrdata=8'h3C -> cromack pulse, cromdata=8'h3C.
- chrramreq, chrramwr=1, chrramaddr=13'h1FFF, wdata=8'h5A -> extaddr=23'h7FFFFF, extwr=1, extwdata=8'h5A; chrramack pulse; chrramrdata unchanged.
- After reset, all three reqs rise in the same cycle, each re-raised after its ack drops -> grant order PRG, CROM, CHRRAM, PRG; each ack follows its extack by 1 cycle.
- promreq held high for 10 cycles past promack -> exactly one external transaction; drop promreq for 1 cycle, raise again -> a second transaction starts.
- reset asserted while extreq=1 -> extreq=0 next cycle, no ack; a later extack pulse is ignored; the next promreq is served normally.
